load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Initiator side of the core's data-memory interface. Accepts one load/store request at a time from the execute stage and decodes RV32I funct3 into a size code, byte address and right-justified write data. Drives the word-organised data memory, which has a one-cycle registered read. Sign-extends load results and reports misaligned, out-of-range and illegal-funct3 requests without touching memory.

Parameters:
ADDR_BITWIDTH, 10, byte-address width of the data memory (2**ADDR_BITWIDTH bytes)

Ports:
LSU_Clk  in  1  clock
LSU_Reset_n  in  1  asynchronous active-low reset
LSU_Req_Valid  in  1  request valid
LSU_Req_Ready  out  1  unit idle, request accepted when Valid&Ready
LSU_Req_Store  in  1  1=store, 0=load
LSU_Req_Funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
LSU_Req_Addr  in  32  byte address
LSU_Req_Wdata  in  32  store data, right-justified
LSU_Req_Rd  in  5  destination tag, returned unchanged
LSU_Rsp_Valid  out  1  response valid
LSU_Rsp_Ready  in  1  consumer accepts response
LSU_Rsp_Rdata  out  32  extended load result (0 for stores/errors)
LSU_Rsp_Rd  out  5  tag of the request
LSU_Rsp_Err  out  2  00 ok, 01 misaligned, 10 access fault, 11 illegal funct3
LSU_Mem_We  out  1  memory write enable
LSU_Mem_Re  out  1  memory read enable (memory output is 0 when low)
LSU_Mem_Byteenable  out  4  size code: 0001 byte, 0011 half, 1111 word
LSU_Mem_Address  out  ADDR_BITWIDTH  byte address to memory
LSU_Mem_Data_Out  out  32  write data, right-justified
LSU_Mem_Data_In  in  32  read data, zero-extended, right-justified

Behaviour:
- Clock and reset: one clock, LSU_Clk. Reset is asynchronous and active-low on LSU_Reset_n.
- Reset values: state IDLE, Req_Ready=1, Rsp_Valid=0, Rsp_Rdata=0, Rsp_Rd=0, Rsp_Err=00, Mem_We=0, Mem_Re=0, Mem_Byteenable=1111, Mem_Address=0, Mem_Data_Out=0.
- All memory-side outputs come from registers: no glitches, and stable for the whole access.
- Request accept: at the accept edge, latch request fields and classify the request.
  - Illegal: load funct3 in {011,110,111}, or store funct3 >= 011.
  - Misaligned: half with Addr[0]=1, or word with Addr[1:0]!=00.
  - Fault: Addr[31:ADDR_BITWIDTH] != 0.
  - Priority is illegal > misaligned > fault.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
  - IDLE -> RESP on accept of an error request. No memory enable is ever asserted.
  - IDLE -> ISSUE on accept of a valid request.
  - ISSUE, store: We=1 for exactly this cycle; memory writes at the cycle's end. Then -> RESP.
  - ISSUE, load: Re=1, address and size presented; memory captures the word at the cycle's end. Then -> CAPTURE.
  - CAPTURE: address and Byteenable held unchanged, because the memory's lane select is combinational on them. Re=1. Mem_Data_In is sampled and extended into Rsp_Rdata. Then -> RESP.
  - RESP: Rsp_Valid=1, held with all fields stable until Rsp_Ready=1. Then -> IDLE, with Req_Ready=1 the following cycle.
- Latency from accept edge to Rsp_Valid, with Rsp_Ready tied high:
  - error: 1 cycle
  - store: 2 cycles
  - load: 3 cycles
- Throughput: one request outstanding; no new accept until the response handshake completes.
- Extension:
  - LB: bits[31:8] = bit7.
  - LH: bits[31:16] = bit15.
  - LBU/LHU: zero-extend.
  - LW: pass through.
- Write data: SB sends Wdata[7:0], SH sends Wdata[15:0], both in the low bits. Upper bits are don't-care and driven 0.
- Mem_We and Mem_Re deassert outside ISSUE/CAPTURE.
- Reset mid-operation aborts the access:
  - We/Re drop immediately (asynchronous).
  - No response is produced.
  - A store aborted before its ISSUE edge is not written.
- Rsp_Ready while Rsp_Valid=0 is ignored.

Decomposition:
- Package lsu_pkg:
  - funct3 constants
  - size codes ONEBYTE/TWOBYTES/FOURBYTES
  - error codes
  - FSM state encoding
- Sub-module lsu_load_extend: combinational funct3 + 32-bit memory word -> extended result. Instantiated in the CAPTURE path and separately unit-testable.

Test Plan:
- SW 0x800080F0 @0x10, then LB/LBU/LH/LHU/LW @0x10 -> LB 0xFFFFFFF0, LBU 0x000000F0, LH 0xFFFF80F0, LHU 0x000080F0, LW 0x800080F0.
- SW 0x11223344 @0x20; SB 0xAB @0x21; SH 0xBEEF @0x22; LW @0x20 -> 0xBEEFAB44; the SB and SH accesses each show We high for exactly one cycle with Byteenable 0001 and 0011 respectively.
- LW @0x13 -> Err=01 one cycle after accept, Rdata=0, We and Re never asserted; LH @0x400 (ADDR_BITWIDTH=10) -> Err=10; load funct3 011 -> Err=11.
- Load issued with Rsp_Ready low for 3 cycles -> Rsp_Valid, Rdata and Rd held stable, Req_Ready=0 throughout, and accepted on the first Ready cycle.
- LSU_Reset_n asserted during CAPTURE -> We/Re/Rsp_Valid go 0 immediately; after release Req_Ready=1 and the next LW returns the correct data.
- Back-to-back store then load to the same address with Req_Valid held high -> load returns the newly stored value; accepts are spaced by the response handshake.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types, constants and decode helpers for the load/store unit.
package lsu_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned RD_W     = 5;
    localparam int unsigned FUNCT3_W = 3;
    localparam int unsigned SIZE_W   = 4;

    // RV32I load/store funct3 encodings
    localparam logic [FUNCT3_W-1:0] F3_B  = 3'b000;
    localparam logic [FUNCT3_W-1:0] F3_H  = 3'b001;
    localparam logic [FUNCT3_W-1:0] F3_W  = 3'b010;
    localparam logic [FUNCT3_W-1:0] F3_BU = 3'b100;
    localparam logic [FUNCT3_W-1:0] F3_HU = 3'b101;

    // Memory size codes
    localparam logic [SIZE_W-1:0] ONEBYTE   = 4'b0001;
    localparam logic [SIZE_W-1:0] TWOBYTES  = 4'b0011;
    localparam logic [SIZE_W-1:0] FOURBYTES = 4'b1111;

    typedef enum logic [1:0] {
        ERR_NONE       = 2'b00,
        ERR_MISALIGNED = 2'b01,
        ERR_FAULT      = 2'b10,
        ERR_ILLEGAL    = 2'b11
    } lsu_err_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ISSUE   = 2'b01,
        ST_CAPTURE = 2'b10,
        ST_RESP    = 2'b11
    } lsu_state_e;

    typedef struct packed {
        logic [XLEN-1:0] rdata;
        logic [RD_W-1:0] rd;
        lsu_err_e        err;
    } lsu_rsp_t;

    // Loads reject 011/110/111; stores only know SB/SH/SW
    function automatic logic is_illegal(input logic store, input logic [FUNCT3_W-1:0] f3);
        if (store) begin
            return (f3 >= 3'b011);
        end
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    // Access size lives in funct3[1:0] for both loads and stores
    function automatic logic [SIZE_W-1:0] size_code(input logic [FUNCT3_W-1:0] f3);
        case (f3[1:0])
            2'b00:   return ONEBYTE;
            2'b01:   return TWOBYTES;
            default: return FOURBYTES;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [FUNCT3_W-1:0] f3, input logic [1:0] a_lo);
        case (f3[1:0])
            2'b01:   return a_lo[0];
            2'b10:   return (a_lo != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    // Keep only the lanes that the store size writes; upper bits forced to 0
    function automatic logic [XLEN-1:0] wdata_align(input logic [FUNCT3_W-1:0] f3, input logic [XLEN-1:0] wd);
        case (f3[1:0])
            2'b00:   return {24'b0, wd[7:0]};
            2'b01:   return {16'b0, wd[15:0]};
            default: return wd;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response handshake between the execute stage and the load/store unit.
interface lsu_if;
    import lsu_pkg::*;

    logic                LSU_Req_Valid;
    logic                LSU_Req_Ready;
    logic                LSU_Req_Store;
    logic [FUNCT3_W-1:0] LSU_Req_Funct3;
    logic [XLEN-1:0]     LSU_Req_Addr;
    logic [XLEN-1:0]     LSU_Req_Wdata;
    logic [RD_W-1:0]     LSU_Req_Rd;
    logic                LSU_Rsp_Valid;
    logic                LSU_Rsp_Ready;
    logic [XLEN-1:0]     LSU_Rsp_Rdata;
    logic [RD_W-1:0]     LSU_Rsp_Rd;
    logic [1:0]          LSU_Rsp_Err;

    modport master (
        output LSU_Req_Valid, LSU_Req_Store, LSU_Req_Funct3, LSU_Req_Addr,
               LSU_Req_Wdata, LSU_Req_Rd, LSU_Rsp_Ready,
        input  LSU_Req_Ready, LSU_Rsp_Valid, LSU_Rsp_Rdata, LSU_Rsp_Rd, LSU_Rsp_Err
    );

    modport slave (
        input  LSU_Req_Valid, LSU_Req_Store, LSU_Req_Funct3, LSU_Req_Addr,
               LSU_Req_Wdata, LSU_Req_Rd, LSU_Rsp_Ready,
        output LSU_Req_Ready, LSU_Rsp_Valid, LSU_Rsp_Rdata, LSU_Rsp_Rd, LSU_Rsp_Err
    );

endinterface

// File: rtl/lsu_load_extend.sv
// Sign/zero extension of a right-justified memory word according to load funct3.
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [FUNCT3_W-1:0] i_funct3,
    input  logic [XLEN-1:0]     i_word,
    output logic [XLEN-1:0]     o_data_c
);

    // Select extension by load type; LW and anything else pass through
    always_comb begin
        o_data_c = i_word;
        case (i_funct3)
            F3_B:    o_data_c = {{24{i_word[7]}}, i_word[7:0]};
            F3_H:    o_data_c = {{16{i_word[15]}}, i_word[15:0]};
            F3_BU:   o_data_c = {24'b0, i_word[7:0]};
            F3_HU:   o_data_c = {16'b0, i_word[15:0]};
            default: o_data_c = i_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one request in flight, registered memory-side outputs.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_BITWIDTH = 10
) (
    input  logic                     LSU_Clk,
    input  logic                     LSU_Reset_n,
    lsu_if.slave                     bus,
    output logic                     LSU_Mem_We,
    output logic                     LSU_Mem_Re,
    output logic [SIZE_W-1:0]        LSU_Mem_Byteenable,
    output logic [ADDR_BITWIDTH-1:0] LSU_Mem_Address,
    output logic [XLEN-1:0]          LSU_Mem_Data_Out,
    input  logic [XLEN-1:0]          LSU_Mem_Data_In
);

    lsu_state_e               r_state;
    logic                     r_req_ready;
    logic                     r_rsp_valid;
    lsu_rsp_t                 r_rsp;
    logic                     r_store;
    logic [FUNCT3_W-1:0]      r_funct3;
    logic                     r_mem_we;
    logic                     r_mem_re;
    logic [SIZE_W-1:0]        r_mem_be;
    logic [ADDR_BITWIDTH-1:0] r_mem_addr;
    logic [XLEN-1:0]          r_mem_dout;

    logic                     w_accept;
    logic                     w_fault;
    lsu_err_e                 w_err;
    logic [XLEN-1:0]          w_ext_data;

    assign w_accept = bus.LSU_Req_Valid & r_req_ready;
    assign w_fault  = |bus.LSU_Req_Addr[XLEN-1:ADDR_BITWIDTH];

    // Classify the incoming request: illegal > misaligned > fault
    always_comb begin
        w_err = ERR_NONE;
        if (is_illegal(bus.LSU_Req_Store, bus.LSU_Req_Funct3)) begin
            w_err = ERR_ILLEGAL;
        end else if (is_misaligned(bus.LSU_Req_Funct3, bus.LSU_Req_Addr[1:0])) begin
            w_err = ERR_MISALIGNED;
        end else if (w_fault) begin
            w_err = ERR_FAULT;
        end
    end

    lsu_load_extend u_load_extend (
        .i_funct3 (r_funct3),
        .i_word   (LSU_Mem_Data_In),
        .o_data_c (w_ext_data)
    );

    // Access sequencer; memory enables are only ever high in ISSUE/CAPTURE
    always_ff @(posedge LSU_Clk or negedge LSU_Reset_n) begin
        if (!LSU_Reset_n) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp       <= '{rdata: '0, rd: '0, err: ERR_NONE};
            r_store     <= 1'b0;
            r_funct3    <= '0;
            r_mem_we    <= 1'b0;
            r_mem_re    <= 1'b0;
            r_mem_be    <= FOURBYTES;
            r_mem_addr  <= '0;
            r_mem_dout  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        r_store     <= bus.LSU_Req_Store;
                        r_funct3    <= bus.LSU_Req_Funct3;
                        r_rsp.rd    <= bus.LSU_Req_Rd;
                        r_rsp.rdata <= '0;
                        r_rsp.err   <= w_err;
                        if (w_err != ERR_NONE) begin
                            r_rsp_valid <= 1'b1;
                            r_state     <= ST_RESP;
                        end else begin
                            r_mem_addr <= bus.LSU_Req_Addr[ADDR_BITWIDTH-1:0];
                            r_mem_be   <= size_code(bus.LSU_Req_Funct3);
                            r_mem_dout <= wdata_align(bus.LSU_Req_Funct3, bus.LSU_Req_Wdata);
                            r_mem_we   <= bus.LSU_Req_Store;
                            r_mem_re   <= ~bus.LSU_Req_Store;
                            r_state    <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (r_store) begin
                        r_mem_we    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    r_mem_re    <= 1'b0;
                    r_rsp.rdata <= w_ext_data;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.LSU_Rsp_Ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.LSU_Req_Ready  = r_req_ready;
    assign bus.LSU_Rsp_Valid  = r_rsp_valid;
    assign bus.LSU_Rsp_Rdata  = r_rsp.rdata;
    assign bus.LSU_Rsp_Rd     = r_rsp.rd;
    assign bus.LSU_Rsp_Err    = r_rsp.err;
    assign LSU_Mem_We         = r_mem_we;
    assign LSU_Mem_Re         = r_mem_re;
    assign LSU_Mem_Byteenable = r_mem_be;
    assign LSU_Mem_Address    = r_mem_addr;
    assign LSU_Mem_Data_Out   = r_mem_dout;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word-organised registered-read memory model.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int unsigned AW = 10;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          mem_we;
    logic          mem_re;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_dout;
    logic [31:0]   mem_din;

    lsu_if u_if ();

    load_store_unit #(.ADDR_BITWIDTH(AW)) dut (
        .LSU_Clk            (clk),
        .LSU_Reset_n        (rst_n),
        .bus                (u_if),
        .LSU_Mem_We         (mem_we),
        .LSU_Mem_Re         (mem_re),
        .LSU_Mem_Byteenable (mem_be),
        .LSU_Mem_Address    (mem_addr),
        .LSU_Mem_Data_Out   (mem_dout),
        .LSU_Mem_Data_In    (mem_din)
    );

    always #5 clk = ~clk;

    // Memory model: registered word read, combinational lane select on address/size
    logic [31:0] mem [256];
    logic [31:0] mem_q;

    function automatic logic [31:0] size_mask(input logic [3:0] be);
        if (be == 4'b0001) return 32'h0000_00FF;
        if (be == 4'b0011) return 32'h0000_FFFF;
        return 32'hFFFF_FFFF;
    endfunction

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr[AW-1:2]] <= (mem[mem_addr[AW-1:2]] & ~(size_mask(mem_be) << (8 * int'(mem_addr[1:0]))))
                                   | ((mem_dout & size_mask(mem_be)) << (8 * int'(mem_addr[1:0])));
        end
        if (mem_re) begin
            mem_q <= mem[mem_addr[AW-1:2]];
        end
    end

    assign mem_din = mem_re ? ((mem_q >> (8 * int'(mem_addr[1:0]))) & size_mask(mem_be)) : 32'h0;

    int n_checks = 0;
    int n_fail   = 0;
    int last_we_cyc;
    int last_re_cyc;
    logic [3:0]  last_be;
    logic [31:0] last_dout;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One full transaction with Rsp_Ready high; checks latency and response fields
    task automatic run_req(input string tag, input logic st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                           input logic [31:0] exp_rdata, input logic [1:0] exp_err, input int exp_lat);
        int lat;
        int guard;
        guard = 0;
        @(negedge clk);
        while (u_if.LSU_Req_Ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check_eq({tag, "/idle"}, 32'(u_if.LSU_Req_Ready), 32'd1);
        u_if.LSU_Req_Valid  = 1'b1;
        u_if.LSU_Req_Store  = st;
        u_if.LSU_Req_Funct3 = f3;
        u_if.LSU_Req_Addr   = a;
        u_if.LSU_Req_Wdata  = wd;
        u_if.LSU_Req_Rd     = rd;
        @(posedge clk);
        @(negedge clk);
        u_if.LSU_Req_Valid = 1'b0;
        lat         = 1;
        last_we_cyc = 0;
        last_re_cyc = 0;
        last_be     = 4'h0;
        last_dout   = 32'h0;
        for (int i = 0; i < 20; i++) begin
            if (mem_we === 1'b1) begin
                last_we_cyc++;
                last_be   = mem_be;
                last_dout = mem_dout;
            end
            if (mem_re === 1'b1) last_re_cyc++;
            if (u_if.LSU_Rsp_Valid === 1'b1) break;
            @(negedge clk);
            lat++;
        end
        check_eq({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, "/rdata"}, u_if.LSU_Rsp_Rdata, exp_rdata);
        check_eq({tag, "/err"}, 32'(u_if.LSU_Rsp_Err), 32'(exp_err));
        check_eq({tag, "/rd"}, 32'(u_if.LSU_Rsp_Rd), 32'(rd));
        @(negedge clk);
        check_eq({tag, "/rsp_drop"}, 32'(u_if.LSU_Rsp_Valid), 32'd0);
    endtask

    initial begin
        int guard;
        u_if.LSU_Req_Valid  = 1'b0;
        u_if.LSU_Req_Store  = 1'b0;
        u_if.LSU_Req_Funct3 = 3'b000;
        u_if.LSU_Req_Addr   = 32'h0;
        u_if.LSU_Req_Wdata  = 32'h0;
        u_if.LSU_Req_Rd     = 5'd0;
        u_if.LSU_Rsp_Ready  = 1'b1;

        // Reset values
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst/req_ready", 32'(u_if.LSU_Req_Ready), 32'd1);
        check_eq("rst/rsp_valid", 32'(u_if.LSU_Rsp_Valid), 32'd0);
        check_eq("rst/rdata", u_if.LSU_Rsp_Rdata, 32'h0);
        check_eq("rst/rd", 32'(u_if.LSU_Rsp_Rd), 32'd0);
        check_eq("rst/err", 32'(u_if.LSU_Rsp_Err), 32'd0);
        check_eq("rst/we", 32'(mem_we), 32'd0);
        check_eq("rst/re", 32'(mem_re), 32'd0);
        check_eq("rst/be", 32'(mem_be), 32'hF);
        check_eq("rst/addr", 32'(mem_addr), 32'h0);
        check_eq("rst/dout", mem_dout, 32'h0);

        // Word store then every load flavour at the same address
        run_req("sw10", 1'b1, F3_W, 32'h10, 32'h8000_80F0, 5'd1, 32'h0, 2'b00, 2);
        check_eq("sw10/we_cycles", 32'(last_we_cyc), 32'd1);
        check_eq("sw10/be", 32'(last_be), 32'hF);
        run_req("lb10",  1'b0, F3_B,  32'h10, 32'h0, 5'd2, 32'hFFFF_FFF0, 2'b00, 3);
        check_eq("lb10/re_cycles", 32'(last_re_cyc), 32'd2);
        run_req("lbu10", 1'b0, F3_BU, 32'h10, 32'h0, 5'd3, 32'h0000_00F0, 2'b00, 3);
        run_req("lh10",  1'b0, F3_H,  32'h10, 32'h0, 5'd4, 32'hFFFF_80F0, 2'b00, 3);
        run_req("lhu10", 1'b0, F3_HU, 32'h10, 32'h0, 5'd5, 32'h0000_80F0, 2'b00, 3);
        run_req("lw10",  1'b0, F3_W,  32'h10, 32'h0, 5'd6, 32'h8000_80F0, 2'b00, 3);

        // Partial stores merge into a word
        run_req("sw20", 1'b1, F3_W, 32'h20, 32'h1122_3344, 5'd7, 32'h0, 2'b00, 2);
        run_req("sb21", 1'b1, F3_B, 32'h21, 32'h1234_56AB, 5'd8, 32'h0, 2'b00, 2);
        check_eq("sb21/we_cycles", 32'(last_we_cyc), 32'd1);
        check_eq("sb21/be", 32'(last_be), 32'h1);
        check_eq("sb21/dout", last_dout, 32'h0000_00AB);
        run_req("sh22", 1'b1, F3_H, 32'h22, 32'hCAFE_BEEF, 5'd9, 32'h0, 2'b00, 2);
        check_eq("sh22/we_cycles", 32'(last_we_cyc), 32'd1);
        check_eq("sh22/be", 32'(last_be), 32'h3);
        check_eq("sh22/dout", last_dout, 32'h0000_BEEF);
        run_req("lw20", 1'b0, F3_W, 32'h20, 32'h0, 5'd10, 32'hBEEF_AB44, 2'b00, 3);

        // Top of the address space is still in range
        run_req("sh3fe",  1'b1, F3_H,  32'h3FE, 32'hFFFF_8001, 5'd11, 32'h0, 2'b00, 2);
        run_req("lh3fe",  1'b0, F3_H,  32'h3FE, 32'h0, 5'd12, 32'hFFFF_8001, 2'b00, 3);
        run_req("lhu3fe", 1'b0, F3_HU, 32'h3FE, 32'h0, 5'd13, 32'h0000_8001, 2'b00, 3);

        // Error requests: one-cycle response, no memory activity
        run_req("lw13", 1'b0, F3_W, 32'h13, 32'h0, 5'd14, 32'h0, 2'b01, 1);
        check_eq("lw13/we_cycles", 32'(last_we_cyc), 32'd0);
        check_eq("lw13/re_cycles", 32'(last_re_cyc), 32'd0);
        run_req("lh400",  1'b0, F3_H,   32'h400, 32'h0, 5'd15, 32'h0, 2'b10, 1);
        check_eq("lh400/re_cycles", 32'(last_re_cyc), 32'd0);
        run_req("ld011",  1'b0, 3'b011, 32'h10,  32'h0, 5'd16, 32'h0, 2'b11, 1);
        run_req("st011",  1'b1, 3'b011, 32'h10,  32'h0, 5'd17, 32'h0, 2'b11, 1);
        check_eq("st011/we_cycles", 32'(last_we_cyc), 32'd0);
        run_req("prio_ill", 1'b0, 3'b011, 32'h413, 32'h0, 5'd18, 32'h0, 2'b11, 1);
        run_req("prio_mis", 1'b0, F3_W,   32'h402, 32'h0, 5'd19, 32'h0, 2'b01, 1);

        // Response back-pressure for three cycles
        u_if.LSU_Rsp_Ready = 1'b0;
        @(negedge clk);
        u_if.LSU_Req_Valid  = 1'b1;
        u_if.LSU_Req_Store  = 1'b0;
        u_if.LSU_Req_Funct3 = F3_W;
        u_if.LSU_Req_Addr   = 32'h10;
        u_if.LSU_Req_Rd     = 5'd7;
        @(posedge clk);
        @(negedge clk);
        u_if.LSU_Req_Valid = 1'b0;
        guard = 0;
        while (u_if.LSU_Rsp_Valid !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        for (int i = 0; i < 3; i++) begin
            check_eq("stall/valid", 32'(u_if.LSU_Rsp_Valid), 32'd1);
            check_eq("stall/rdata", u_if.LSU_Rsp_Rdata, 32'h8000_80F0);
            check_eq("stall/rd", 32'(u_if.LSU_Rsp_Rd), 32'd7);
            check_eq("stall/req_ready", 32'(u_if.LSU_Req_Ready), 32'd0);
            @(negedge clk);
        end
        u_if.LSU_Rsp_Ready = 1'b1;
        @(negedge clk);
        check_eq("stall/released_valid", 32'(u_if.LSU_Rsp_Valid), 32'd0);
        check_eq("stall/released_ready", 32'(u_if.LSU_Req_Ready), 32'd1);

        // Reset during CAPTURE of a load
        u_if.LSU_Req_Valid  = 1'b1;
        u_if.LSU_Req_Funct3 = F3_W;
        u_if.LSU_Req_Addr   = 32'h20;
        u_if.LSU_Req_Rd     = 5'd20;
        @(posedge clk);
        @(negedge clk);
        u_if.LSU_Req_Valid = 1'b0;
        @(negedge clk);
        check_eq("rstcap/re_before", 32'(mem_re), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("rstcap/re", 32'(mem_re), 32'd0);
        check_eq("rstcap/we", 32'(mem_we), 32'd0);
        check_eq("rstcap/rsp_valid", 32'(u_if.LSU_Rsp_Valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rstcap/no_rsp", 32'(u_if.LSU_Rsp_Valid), 32'd0);
        check_eq("rstcap/req_ready", 32'(u_if.LSU_Req_Ready), 32'd1);
        run_req("rstcap_lw20", 1'b0, F3_W, 32'h20, 32'h0, 5'd21, 32'hBEEF_AB44, 2'b00, 3);

        // Reset before the ISSUE edge of a store drops the write
        @(negedge clk);
        u_if.LSU_Req_Valid  = 1'b1;
        u_if.LSU_Req_Store  = 1'b1;
        u_if.LSU_Req_Funct3 = F3_W;
        u_if.LSU_Req_Addr   = 32'h10;
        u_if.LSU_Req_Wdata  = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        u_if.LSU_Req_Valid = 1'b0;
        check_eq("rstst/we_before", 32'(mem_we), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("rstst/we", 32'(mem_we), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_req("rstst_lw10", 1'b0, F3_W, 32'h10, 32'h0, 5'd22, 32'h8000_80F0, 2'b00, 3);

        // Back-to-back store then load with Req_Valid held high
        @(negedge clk);
        u_if.LSU_Req_Valid  = 1'b1;
        u_if.LSU_Req_Store  = 1'b1;
        u_if.LSU_Req_Funct3 = F3_W;
        u_if.LSU_Req_Addr   = 32'h30;
        u_if.LSU_Req_Wdata  = 32'h5A5A_1234;
        u_if.LSU_Req_Rd     = 5'd3;
        @(posedge clk);
        @(negedge clk);
        u_if.LSU_Req_Store  = 1'b0;
        u_if.LSU_Req_Rd     = 5'd4;
        guard = 1;
        begin
            int seen;
            seen = 0;
            while (u_if.LSU_Req_Ready !== 1'b1 && guard < 20) begin
                if (u_if.LSU_Rsp_Valid === 1'b1) seen = 1;
                @(negedge clk);
                guard++;
            end
            check_eq("b2b/store_rsp_seen", 32'(seen), 32'd1);
        end
        check_eq("b2b/accept_gap", 32'(guard), 32'd3);
        @(posedge clk);
        @(negedge clk);
        u_if.LSU_Req_Valid = 1'b0;
        guard = 1;
        while (u_if.LSU_Rsp_Valid !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check_eq("b2b/load_latency", 32'(guard), 32'd3);
        check_eq("b2b/rdata", u_if.LSU_Rsp_Rdata, 32'h5A5A_1234);
        check_eq("b2b/rd", 32'(u_if.LSU_Rsp_Rd), 32'd4);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
